// File: rtl/alu_seq_responder.sv
// alu_seq_responder
//   Handshaked multi-cycle ALU. Accepts one (src1, src2, ALU_control)
//   operation per transaction and holds result/flags until taken.
//   Logic and arithmetic ops take one cycle. Shifts take one cycle per bit.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid / in_ready    operation handshake (in_ready high only in IDLE)
//   src1, src2             operands (shift amount is src2[4:0])
//   ALU_control            4-bit opcode
//   out_valid / out_ready  result handshake
//   result, zero, cout, overflow   registered result and flags
module alu_seq_responder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic [3:0]  ALU_control,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        zero,
  output logic        cout,
  output logic        overflow
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0110,
    OP_SLT = 4'b0111,
    OP_NOR = 4'b1100,
    OP_SLL = 4'b1000,
    OP_SRL = 4'b1001
  } op_t;

  state_t      state, state_nxt;
  logic [31:0] work;
  logic [4:0]  cnt;
  logic        shift_right;

  logic        accept;
  logic        start_shift;
  logic        sub_mode;
  logic [31:0] b_eff;
  logic [32:0] sum;
  logic        add_v;
  logic [31:0] alu_res;
  logic        alu_c;
  logic        alu_v;
  logic [31:0] shifted;

  assign accept      = in_valid && (state == IDLE);
  assign start_shift = ((ALU_control == OP_SLL) || (ALU_control == OP_SRL)) &&
                       (src2[4:0] != 5'd0);
  assign shifted     = shift_right ? {1'b0, work[31:1]} : {work[30:0], 1'b0};

  // Single-cycle datapath; SUB and SLT share the adder as src1 + ~src2 + 1,
  // so the same sign rule yields overflow for both add and subtract.
  always_comb begin
    sub_mode = (ALU_control == OP_SUB) || (ALU_control == OP_SLT);
    b_eff    = sub_mode ? ~src2 : src2;
    sum      = {1'b0, src1} + {1'b0, b_eff} + {32'b0, sub_mode};
    add_v    = (src1[31] == b_eff[31]) && (sum[31] != src1[31]);
    alu_res  = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    case (op_t'(ALU_control))
      OP_AND: alu_res = src1 & src2;
      OP_OR:  alu_res = src1 | src2;
      OP_NOR: alu_res = ~(src1 | src2);
      OP_ADD, OP_SUB: begin
        alu_res = sum[31:0];
        alu_c   = sum[32];
        alu_v   = add_v;
      end
      OP_SLT: alu_res = {31'b0, sum[31] ^ add_v};
      OP_SLL, OP_SRL: alu_res = src1;  // only reached with a zero amount
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = start_shift ? SHIFT : DONE;
      end
      SHIFT: begin
        if (cnt == 5'd1) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work        <= '0;
      cnt         <= '0;
      shift_right <= 1'b0;
      result      <= '0;
      zero        <= 1'b0;
      cout        <= 1'b0;
      overflow    <= 1'b0;
    end else if (accept) begin
      if (start_shift) begin
        work        <= src1;
        cnt         <= src2[4:0];
        shift_right <= ALU_control[0];
      end else begin
        result   <= alu_res;
        zero     <= (alu_res == '0);
        cout     <= alu_c;
        overflow <= alu_v;
      end
    end else if (state == SHIFT) begin
      work <= shifted;
      cnt  <= cnt - 5'd1;
      if (cnt == 5'd1) begin
        result   <= shifted;
        zero     <= (shifted == '0);
        cout     <= 1'b0;
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_responder.sv
module tb_alu_seq_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [3:0]  ALU_control;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        cout;
  logic        overflow;

  alu_seq_responder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .src1        (src1),
    .src2        (src2),
    .ALU_control (ALU_control),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .cout        (cout),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  zcv;
    int unsigned lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;
  int   fails  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    assert (got === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  // Reference model: signed ranges in 64-bit arithmetic rather than an adder.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sa;
    longint      sbv;
    longint      s;
    logic [32:0] u;
    logic        c;
    logic        v;
    int unsigned n;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    n   = int'(b[4:0]);
    c   = 1'b0;
    v   = 1'b0;
    e.res = '0;
    e.lat = 1;
    case (op)
      4'b0000: e.res = a & b;
      4'b0001: e.res = a | b;
      4'b1100: e.res = ~(a | b);
      4'b0010: begin
        u = {1'b0, a} + {1'b0, b};
        e.res = u[31:0];
        c = u[32];
        s = sa + sbv;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0110: begin
        e.res = a - b;
        c = (a >= b);
        s = sa - sbv;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0111: e.res = (sa < sbv) ? 32'd1 : 32'd0;
      4'b1000: begin e.res = a << n; e.lat = n + 1; end
      4'b1001: begin e.res = a >> n; e.lat = n + 1; end
      default: e.res = '0;
    endcase
    e.zcv = {(e.res == 32'd0), c, v};
    return e;
  endfunction

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned w = 0;
    while (in_ready !== 1'b1 && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    chk("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
    src1        = a;
    src2        = b;
    ALU_control = op;
    in_valid    = 1'b1;
    sb.push_back(model(op, a, b));
    @(posedge clk); #1;
    in_valid    = 1'b0;
    src1        = $urandom;
    src2        = $urandom;
    ALU_control = 4'($urandom);
  endtask

  // Called #1 after the accept edge; cycle 1 is the one following that edge.
  task automatic collect(input string tag, input int unsigned hold);
    exp_t        e;
    int unsigned lat = 1;
    logic        busy_ok = 1'b1;
    logic        stable = 1'b1;
    logic [31:0] r0;
    logic [2:0]  f0;
    while (out_valid !== 1'b1 && lat < 40) begin
      busy_ok &= (in_ready === 1'b0);
      @(posedge clk); #1;
      lat++;
    end
    busy_ok &= (in_ready === 1'b0);
    chk({tag, "_in_ready_low"}, {31'b0, busy_ok}, 32'd1);
    if (sb.size() == 0) begin
      chk({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_latency"}, lat, e.lat);
      chk({tag, "_result"}, result, e.res);
      chk({tag, "_zcv"}, {29'b0, zero, cout, overflow}, {29'b0, e.zcv});
    end
    if (hold > 0) begin
      r0 = result;
      f0 = {zero, cout, overflow};
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int unsigned i = 0; i < hold; i++) begin
        src1        = $urandom;
        src2        = $urandom;
        ALU_control = 4'($urandom);
        @(posedge clk); #1;
        stable &= (result === r0) && ({zero, cout, overflow} === f0) &&
                  (out_valid === 1'b1) && (in_ready === 1'b0);
      end
      in_valid = 1'b0;
      chk({tag, "_hold_stable"}, {31'b0, stable}, 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_in_ready_after"}, {31'b0, in_ready}, 32'd1);
    chk({tag, "_out_valid_after"}, {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    src1        = '0;
    src2        = '0;
    ALU_control = '0;
    #12;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_result", result, 32'd0);
    chk("rst_zcv", {29'b0, zero, cout, overflow}, 32'd0);
    #5 rst_n = 1'b1;
    @(posedge clk); #1;

    issue(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001); collect("add_ovf", 0);
    issue(4'b0010, 32'hFFFF_FFFF, 32'h0000_0001); collect("add_carry", 0);
    issue(4'b0110, 32'd5, 32'd5);                 collect("sub_zero", 0);
    issue(4'b0110, 32'h8000_0000, 32'd1);         collect("sub_ovf", 0);
    issue(4'b0111, 32'h8000_0000, 32'd1);         collect("slt_neg", 0);
    issue(4'b1000, 32'd1, 32'h0000_003F);         collect("sll_31", 0);
    issue(4'b1001, 32'hF000_0000, 32'd4);         collect("srl_4", 0);
    issue(4'b1000, 32'h1234_5678, 32'hFFFF_FFE0); collect("sll_0", 0);
    issue(4'b0001, 32'hA5A5_0000, 32'h0000_5A5A); collect("or_backpressure", 10);

    // Consumer ready before the result: DONE lasts a single cycle.
    issue(4'b1100, 32'hF0F0_F0F0, 32'h0F0F_0F00);
    out_ready = 1'b1;
    collect("nor_early_ready", 0);

    // Reset during a 20-bit shift drops the transaction.
    issue(4'b1000, 32'd1, 32'd20);
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_zcv", {29'b0, zero, cout, overflow}, 32'd0);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    if (sb.size() > 0) void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    issue(4'b0000, 32'hFF00_FF00, 32'h0FF0_0FF0); collect("and_after_rst", 0);

    issue(4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF); collect("undef_op", 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/alu_seq_responder.md
# alu_seq_responder

Handshaked, multi-cycle responder for the ALU operand/opcode interface. It accepts one operation (src1, src2, ALU_control) per transaction, computes result and zero/cout/overflow flags, and holds them until the consumer takes them. Logic and arithmetic ops finish in one cycle. Shifts are iterative, one bit per cycle. It sits between an instruction-issue stage or vector driver and a result consumer, replacing the purely combinational ALU where backpressure is needed.

## Interface
Parameters: none (fixed 32-bit datapath, 4-bit opcode).

- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operation offered
- in_ready  out  1  responder can accept; high only in IDLE
- src1  in  32  operand A
- src2  in  32  operand B; for shifts, the amount is src2[4:0]
- ALU_control  in  4  opcode
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer takes result
- result  out  32  operation result
- zero  out  1  result == 0
- cout  out  1  carry out, ADD/SUB only
- overflow  out  1  signed overflow, ADD/SUB only

## Operation
Opcodes (all others are undefined):
- 0000 AND
- 0001 OR
- 0010 ADD
- 0110 SUB (src1 + ~src2 + 1)
- 0111 SLT, signed; result = {31'b0, diff[31]^ovf}
- 1100 NOR
- 1000 SLL
- 1001 SRL (logical)

Flags:
- ADD: cout = carry out of bit 31; overflow = operand signs equal and result sign differs.
- SUB: cout = carry out of bit 31 of src1 + ~src2 + 1, so 1 means no borrow; overflow = operand signs differ and result sign differs from src1.
- All other ops: cout = 0, overflow = 0.
- zero is computed from the final result for every op.
- Undefined opcode: result 0, zero 1, cout 0, overflow 0, latency as a single-cycle op.

FSM states: IDLE, SHIFT, DONE.
- IDLE: in_ready = 1. On in_valid && in_ready, latch src1, src2, ALU_control.
  - Shift with amount n > 0: load the working register with src1 and a counter with n; go to SHIFT.
  - Any other op, or a shift with n = 0: register the result and flags; go to DONE.
- SHIFT: shift the working register by one bit per cycle and decrement the counter. When the counter reaches 1, write the final value to result, compute zero, and go to DONE.
- DONE: out_valid = 1; result and flags are held stable. On out_ready, go to IDLE.

Inputs are sampled only on the accept cycle. Changes to src1, src2 or ALU_control afterwards do not affect the transaction in flight.

## Timing
Reset values: out_valid 0, result 0, zero 0, cout 0, overflow 0, state IDLE (so in_ready = 1), shift counter 0.

Latency, counted from the accept edge:
- out_valid rises 1 cycle later for single-cycle ops and for shifts with n = 0.
- out_valid rises 1 + n cycles later for shifts with n ≥ 1 (maximum 32).

Handshake rules:
- in_ready is 0 in SHIFT and DONE; in_valid is ignored there.
- Handshake completes on the edge where out_valid && out_ready are both high. in_ready returns high the next cycle.
- No overlap of transactions: minimum period is 2 cycles (single-cycle ops) or 2 + n cycles (shifts).

Boundary conditions:
- out_ready may be high before out_valid; DONE then lasts exactly one cycle.
- Outputs do not change while out_valid && !out_ready.
- rst_n asserted in any state clears all outputs immediately and without a clock; the in-flight transaction is dropped. The first edge after release can accept.
- Shift amount uses src2[4:0] only; src2[31:5] is ignored.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001 -> result 0x80000000, zero/cout/overflow = 001, out_valid 1 cycle after accept. ADD 0xFFFFFFFF + 1 -> result 0, zcv 110.
- SUB 5 − 5 -> result 0, zcv 110. SUB 0x80000000 − 1 -> result 0x7FFFFFFF, zcv 011. SLT 0x80000000 vs 1 -> result 1, zcv 000.
- SLL src1 = 1, src2 = 0x3F (n = 31) -> result 0x80000000, out_valid 32 cycles after accept, in_ready 0 throughout. SRL 0xF0000000 by 4 -> 0x0F000000, latency 5. SLL by 0 -> src1 unchanged, latency 1.
- Backpressure: hold out_ready low for 10 cycles with in_valid high and changing operands -> result/flags stable, no second accept. Raise out_ready -> in_ready high the next cycle.
- Assert rst_n low mid-SHIFT (SLL n = 20, at cycle 7) -> out_valid, result and flags 0 immediately. After release, AND 0xFF00FF00 & 0x0FF00FF0 -> 0x0F000F00, zcv 000.
- Undefined opcode 1111 with src1 = src2 = 0xFFFFFFFF -> result 0, zcv 100, latency 1.
